// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer with HI/LO registers for the EX stage.
// Holds MD-class instructions in ID while a multiply or divide is in flight.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_sel,
    input  logic        md_use_d,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    localparam int CW = 16;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [1:0]     op_q, op_d;

    logic [63:0]    smul;
    logic [63:0]    umul;
    logic           a_neg;
    logic           b_neg;
    logic [31:0]    abs_a;
    logic [31:0]    abs_b;
    logic [31:0]    uq;
    logic [31:0]    ur;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;
    logic           div_zero;

    // Products from the latched operands; stable for the whole RUN phase.
    assign smul = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign umul = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly.
    always_comb begin
        a_neg    = (op_q == OP_DIV) && a_q[31];
        b_neg    = (op_q == OP_DIV) && b_q[31];
        abs_a    = a_neg ? (~a_q + 32'd1) : a_q;
        abs_b    = b_neg ? (~b_q + 32'd1) : b_q;
        div_zero = (b_q == 32'd0);
        uq       = div_zero ? 32'd0 : abs_a / abs_b;
        ur       = div_zero ? 32'd0 : abs_a % abs_b;
    end

    // Result mux by latched opcode.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (op_q)
            OP_MULT:  {res_hi, res_lo} = smul;
            OP_MULTU: {res_hi, res_lo} = umul;
            OP_DIV: begin
                res_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
                res_hi = a_neg ? (~ur + 32'd1) : ur;
            end
            OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
            end
            default: ;
        endcase
    end

    // State register and datapath latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    // Next-state: issue, MT* writes, countdown and commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    if (!md_op[2]) begin
                        a_d     = rs_val;
                        b_d     = rt_val;
                        op_d    = md_op[1:0];
                        cnt_d   = md_op[1] ? CW'(DIV_CYCLES)
                                           : CW'(MULT_CYCLES);
                        state_d = RUN;
                    end else if (md_op == 3'd4) begin
                        hi_d = rs_val;
                    end else if (md_op == 3'd5) begin
                        lo_d = rs_val;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!(op_q[1] && div_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q == RUN);
    assign md_rdata  = mf_sel ? lo_q : hi_q;
    assign stall_req = md_use_d & (busy | (md_start & ~md_op[2]));

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: vector table with a result
// scoreboard, plus directed sequences for stall, reset-abort and MT* cases.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_sel;
    logic        md_use_d;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int n_cmp = 0;
    int n_err = 0;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mf_sel    (mf_sel),
        .md_use_d  (md_use_d),
        .md_rdata  (md_rdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    typedef struct {
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one MULT/DIV, count busy cycles, then check against scoreboard.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc);
        exp_t e;
        int   n;
        sb.push_back('{ehi, elo, ecyc});
        md_start = 1'b1;
        md_op    = op;
        rs_val   = rs;
        rt_val   = rt;
        tick();
        md_start = 1'b0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
        e = sb.pop_front();
        chk({name, " cycles"}, n, e.ecyc);
        chk({name, " hi"}, hi, e.ehi);
        chk({name, " lo"}, lo, e.elo);
        mf_sel = 1'b0;
        #1;
        chk({name, " rdata_hi"}, md_rdata, e.ehi);
        mf_sel = 1'b1;
        #1;
        chk({name, " rdata_lo"}, md_rdata, e.elo);
        mf_sel = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10};
        vecs[5] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 5};
        vecs[6] = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10};
        vecs[7] = '{3'd3, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 10};
        vecs[8] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5};

        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = 3'd7;
        rs_val   = '0;
        rt_val   = '0;
        mf_sel   = 1'b0;
        md_use_d = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, stall_req}, 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs,
                   vecs[i].rt, vecs[i].ehi, vecs[i].elo, vecs[i].ecyc);
        end

        // MTHI / MTLO then divide by zero leaves HI/LO untouched.
        md_start = 1'b1;
        md_op    = 3'd4;
        rs_val   = 32'h11;
        tick();
        chk("mthi hi", hi, 32'h11);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        md_op  = 3'd5;
        rs_val = 32'h22;
        tick();
        md_start = 1'b0;
        chk("mtlo lo", lo, 32'h22);
        chk("mtlo hi kept", hi, 32'h11);
        run_op("div0", 3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        run_op("divu0", 3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10);

        // No-op opcode with start changes nothing.
        md_start = 1'b1;
        md_op    = 3'd6;
        rs_val   = 32'hDEAD;
        tick();
        md_start = 1'b0;
        chk("nop hi", hi, 32'h11);
        chk("nop lo", lo, 32'h22);
        chk("nop busy", {31'd0, busy}, 32'd0);

        // Stall through MULT; MTLO issued while busy is ignored.
        md_use_d = 1'b1;
        md_start = 1'b1;
        md_op    = 3'd0;
        rs_val   = 32'd2;
        rt_val   = 32'd3;
        #1;
        chk("stall issue", {31'd0, stall_req}, 32'd1);
        tick();
        md_start = 1'b0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            chk($sformatf("stall busy%0d", n), {31'd0, stall_req}, 32'd1);
            if (n == 2) begin
                md_start = 1'b1;
                md_op    = 3'd5;
                rs_val   = 32'hBEEF;
            end else begin
                md_start = 1'b0;
            end
            tick();
        end
        md_start = 1'b0;
        #1;
        chk("stall cycles", n, 5);
        chk("stall after", {31'd0, stall_req}, 32'd0);
        chk("stall lo", lo, 32'd6);
        chk("stall hi", hi, 32'd0);
        md_use_d = 1'b0;

        // Reset on busy cycle 3 of a DIV aborts with no later commit.
        md_start = 1'b1;
        md_op    = 3'd2;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        chk("abort busy pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy || hi != 0 || lo != 0) n++;
        end
        chk("abort no commit", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
